// File: rtl/fft_twiddle_fetch_pkg.sv
// Shared FFT definitions: default twiddle geometry and the fetch FSM state encoding.
package fft_twiddle_fetch_pkg;

  localparam int unsigned ADDR_W_DEF = 5;
  localparam int unsigned DATA_W_DEF = 16;
  localparam int unsigned NUM_TW_DEF = 28;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2
  } tw_state_e;

endpackage

// File: rtl/fft_tw_skid_fifo.sv
// Two-entry skid buffer for twiddle pairs; the head entry drives the outputs straight from flops.
module fft_tw_skid_fifo
  import fft_twiddle_fetch_pkg::*;
#(
  parameter int unsigned W = ADDR_W_DEF + 2 * DATA_W_DEF
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push_i,
  input  logic [W-1:0] data_i,
  input  logic         pop_i,
  output logic         valid_o,
  output logic [W-1:0] data_o,
  output logic         skid_valid_o
);

  logic         out_valid_q, out_valid_d;
  logic [W-1:0] out_data_q, out_data_d;
  logic         skid_valid_q, skid_valid_d;
  logic [W-1:0] skid_data_q, skid_data_d;

  // Head refills from the skid entry first so ordering is preserved.
  always_comb begin
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    skid_valid_d = skid_valid_q;
    skid_data_d  = skid_data_q;
    if (pop_i || !out_valid_q) begin
      if (skid_valid_q) begin
        out_valid_d  = 1'b1;
        out_data_d   = skid_data_q;
        skid_valid_d = push_i;
        if (push_i) skid_data_d = data_i;
      end else begin
        out_valid_d = push_i;
        if (push_i) out_data_d = data_i;
      end
    end else if (push_i) begin
      skid_valid_d = 1'b1;
      skid_data_d  = data_i;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      skid_valid_q <= 1'b0;
      skid_data_q  <= '0;
    end else begin
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      skid_valid_q <= skid_valid_d;
      skid_data_q  <= skid_data_d;
    end
  end

  assign valid_o      = out_valid_q;
  assign data_o       = out_data_q;
  assign skid_valid_o = skid_valid_q;

endmodule

// File: rtl/fft_twiddle_fetch.sv
// Streams NUM_TW twiddle pairs from external ROMs to the butterfly with credit-based flow control.
// Define TWIDDLE_CONJ_EN to emit the conjugate twiddle (saturating negated imaginary part).
module fft_twiddle_fetch
  import fft_twiddle_fetch_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned NUM_TW = NUM_TW_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_re,
  input  logic [DATA_W-1:0] rom_im,
  output logic              tw_valid,
  input  logic              tw_ready,
  output logic [DATA_W-1:0] tw_re,
  output logic [DATA_W-1:0] tw_im,
  output logic [ADDR_W-1:0] tw_idx
);

  localparam int unsigned      PAIR_W    = ADDR_W + 2 * DATA_W;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_TW - 1);

  tw_state_e         state_q, state_d;
  logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
  logic              inflight_q, inflight_d;
  logic [ADDR_W-1:0] tag_q, tag_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic              issue_c;
  logic              pop_c;
  logic              credit_ok_c;
  logic [1:0]        occ_after_pop_c;
  logic              head_valid;
  logic              skid_valid;
  logic [PAIR_W-1:0] head_data;
  logic [PAIR_W-1:0] push_data;
  logic [DATA_W-1:0] cap_im;

`ifdef TWIDDLE_CONJ_EN
  localparam logic [DATA_W-1:0] IM_MIN = {1'b1, {(DATA_W - 1) {1'b0}}};
  assign cap_im = (rom_im == IM_MIN) ? ~IM_MIN : (~rom_im + DATA_W'(1));
`else
  assign cap_im = rom_im;
`endif

  assign pop_c           = head_valid & tw_ready;
  // Occupancy after this cycle's pop, so a pair leaving frees a slot for a new address at once.
  assign occ_after_pop_c = 2'({1'b0, head_valid} + {1'b0, skid_valid} - {1'b0, pop_c});
  assign credit_ok_c     = (2'({1'b0, inflight_q} + occ_after_pop_c) < 2'd2);
  // rom_addr idles at 0, so an accepted start issues address 0 in its own cycle.
  assign issue_c         = ((state_q == IDLE) && start) || ((state_q == FETCH) && credit_ok_c);
  assign push_data       = {tag_q, rom_re, cap_im};

  always_comb begin
    state_d    = state_q;
    rom_addr_d = rom_addr_q;
    inflight_d = issue_c;
    tag_d      = rom_addr_q;
    done_d     = 1'b0;
    if (issue_c) begin
      if (rom_addr_q == LAST_ADDR) begin
        rom_addr_d = '0;
        state_d    = DRAIN;
      end else begin
        rom_addr_d = rom_addr_q + ADDR_W'(1);
        state_d    = FETCH;
      end
    end
    if ((state_q == DRAIN) && pop_c && (tw_idx == LAST_ADDR)) begin
      state_d = IDLE;
      done_d  = 1'b1;
    end
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      rom_addr_q <= '0;
      inflight_q <= 1'b0;
      tag_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      rom_addr_q <= rom_addr_d;
      inflight_q <= inflight_d;
      tag_q      <= tag_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  fft_tw_skid_fifo #(
    .W(PAIR_W)
  ) u_skid_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .push_i      (inflight_q),
    .data_i      (push_data),
    .pop_i       (pop_c),
    .valid_o     (head_valid),
    .data_o      (head_data),
    .skid_valid_o(skid_valid)
  );

  assign busy     = busy_q;
  assign done     = done_q;
  assign rom_addr = rom_addr_q;
  assign tw_valid = head_valid;
  assign tw_idx   = head_data[PAIR_W-1 -: ADDR_W];
  assign tw_re    = head_data[2*DATA_W-1 -: DATA_W];
  assign tw_im    = head_data[DATA_W-1:0];

endmodule

// File: tb/tb_fft_twiddle_fetch.sv
// Scoreboard bench for fft_twiddle_fetch: stimulus queues expected pairs, a monitor checks transfers.
module tb_fft_twiddle_fetch;

  localparam int unsigned AW = 5;
  localparam int unsigned DW = 16;
  localparam int unsigned NT = 28;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          tw_ready = 1'b1;
  logic          busy, done, tw_valid;
  logic [AW-1:0] rom_addr, tw_idx;
  logic [DW-1:0] rom_re = '0;
  logic [DW-1:0] rom_im = '0;
  logic [DW-1:0] tw_re, tw_im;

  typedef struct packed {
    logic [AW-1:0] idx;
    logic [DW-1:0] re;
    logic [DW-1:0] im;
  } pair_t;

  pair_t sb[$];
  int    checks = 0;
  int    errors = 0;

  fft_twiddle_fetch #(.ADDR_W(AW), .DATA_W(DW), .NUM_TW(NT)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
    .rom_addr(rom_addr), .rom_re(rom_re), .rom_im(rom_im),
    .tw_valid(tw_valid), .tw_ready(tw_ready),
    .tw_re(tw_re), .tw_im(tw_im), .tw_idx(tw_idx)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] rom_re_of(int a);
    return 16'(32'h1000 + a * 17);
  endfunction

  function automatic logic [DW-1:0] rom_im_of(int a);
    case (a)
      5:       return 16'hFF00;
      7:       return 16'hFF4A;
      9:       return 16'h8000;
      default: return 16'(32'h2000 + a * 3);
    endcase
  endfunction

  function automatic logic [DW-1:0] exp_im_of(int a);
`ifdef TWIDDLE_CONJ_EN
    case (a)
      5:       return 16'h0100;
      7:       return 16'h00B6;
      9:       return 16'h7FFF;
      default: return 16'(32'h10000 - (32'h2000 + a * 3));
    endcase
`else
    return rom_im_of(a);
`endif
  endfunction

  // Synchronous ROM pair: data for the presented address appears one cycle later.
  always @(posedge clk) begin
    rom_re <= rom_re_of(int'(rom_addr));
    rom_im <= rom_im_of(int'(rom_addr));
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push_run();
    for (int a = 0; a < int'(NT); a++) sb.push_back({AW'(a), rom_re_of(a), exp_im_of(a)});
  endtask

  task automatic check_zero_outputs(input string tag);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_done"}, 64'(done), 64'd0);
    chk({tag, "_valid"}, 64'(tw_valid), 64'd0);
    chk({tag, "_rom_addr"}, 64'(rom_addr), 64'd0);
    chk({tag, "_tw_re"}, 64'(tw_re), 64'd0);
    chk({tag, "_tw_im"}, 64'(tw_im), 64'd0);
    chk({tag, "_tw_idx"}, 64'(tw_idx), 64'd0);
  endtask

  // Expects to be entered just after the edge that sampled start.
  task automatic post_start_checks();
    @(negedge clk);
    chk("c1_busy", 64'(busy), 64'd1);
    chk("c1_valid", 64'(tw_valid), 64'd0);
    @(negedge clk);
    chk("c2_valid", 64'(tw_valid), 64'd1);
    chk("c2_idx", 64'(tw_idx), 64'd0);
  endtask

  task automatic do_start();
    @(posedge clk); #1;
    chk("start_rom_addr", 64'(rom_addr), 64'd0);
    start = 1'b1;
    push_run();
    @(posedge clk); #1;
    start = 1'b0;
    post_start_checks();
  endtask

  // Monitor: pops the scoreboard on each transfer, checks done timing, stall hold and address lead.
  logic  exp_done = 1'b0;
  int    accepted = 0;
  logic  prev_v = 1'b0;
  logic  prev_r = 1'b0;
  logic [AW+2*DW:0] prev_bus = '0;

  always @(negedge clk) begin
    if (!rst_n) begin
      exp_done = 1'b0;
      accepted = 0;
      prev_v   = 1'b0;
    end else begin
      if (done || exp_done) begin
        chk("done_pulse", 64'({done, busy}), 64'({exp_done, 1'b0}));
        if (exp_done) accepted = 0;
      end
      exp_done = 1'b0;
      if (prev_v && !prev_r)
        chk("stall_hold", 64'({tw_valid, tw_idx, tw_re, tw_im}), 64'(prev_bus));
      if (busy) chk("addr_lead", 64'(int'(rom_addr) <= accepted + 2), 64'd1);
      if (tw_valid && tw_ready) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_pair: got idx %0d expected none", tw_idx);
        end else begin
          pair_t e;
          e = sb.pop_front();
          chk("pair", 64'({tw_idx, tw_re, tw_im}), 64'(e));
        end
        accepted++;
        if (tw_idx == AW'(NT - 1)) exp_done = 1'b1;
      end
      prev_v   = tw_valid;
      prev_r   = tw_ready;
      prev_bus = {tw_valid, tw_idx, tw_re, tw_im};
    end
  end

  logic pat[4];
  int   n;
  int   p;

  initial begin
    pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b0; pat[3] = 1'b1;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_zero_outputs("reset");
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Run 1: ready held high, back-to-back transfers, start ignored while busy
    tw_ready = 1'b1;
    do_start();
    for (int k = 0; k < int'(NT); k++) begin
      if (k > 0) @(negedge clk);
      chk("run1_consec_valid", 64'(tw_valid), 64'd1);
      chk("run1_idx", 64'(tw_idx), 64'(k));
      if (k == 5) chk("run1_im_at5", 64'(tw_im), 64'(exp_im_of(5)));
      if (k == 3) start = 1'b1;
      if (k == 4) start = 1'b0;
    end
    @(negedge clk);
    chk("run1_done", 64'(done), 64'd1);
    chk("run1_busy_drop", 64'(busy), 64'd0);
    repeat (3) @(negedge clk);

    // Run 2: ready pattern 1,0,0,1; restart in the done cycle
    do_start();
    p = 0;
    @(posedge clk); #1;
    while (!done && p < 400) begin
      tw_ready = pat[p % 4];
      p++;
      @(posedge clk); #1;
    end
    chk("run2_done_seen", 64'(done), 64'd1);
    chk("run2_restart_rom_addr", 64'(rom_addr), 64'd0);
    start    = 1'b1;
    tw_ready = 1'b1;
    push_run();
    @(posedge clk); #1;
    start = 1'b0;
    post_start_checks();

    // Run 3: reset for one cycle while tw_idx is 10
    n = 0;
    while (!(tw_valid && tw_idx == AW'(9)) && n < 60) begin
      @(negedge clk);
      n++;
    end
    chk("run3_reach_idx9", 64'(n < 60), 64'd1);
    @(posedge clk); #1;
    chk("run3_idx_at_reset", 64'(tw_idx), 64'd10);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check_zero_outputs("midrun_reset");
    sb.delete();
    repeat (5) begin
      @(negedge clk);
      chk("no_done_after_abort", 64'(done), 64'd0);
    end

    // Run 4: fresh run after abort starts again from address 0
    do_start();
    n = 0;
    while (!done && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("run4_done", 64'(done), 64'd1);
    repeat (3) @(negedge clk);
    chk("scoreboard_empty", 64'(sb.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/fft_twiddle_fetch.md
FFT_TWIDDLE_FETCH -- requirements
Module: fft_twiddle_fetch

Interface
REQ-001 SHALL have parameter ADDR_W, default 5, meaning twiddle ROM address width.
REQ-002 SHALL have parameter DATA_W, default 16, meaning twiddle component width (two's complement).
REQ-003 SHALL have parameter NUM_TW, default 28, meaning number of twiddle entries fetched per run (addresses 0..NUM_TW-1).
REQ-004 SHALL have port clk  input  1  rising-edge clock, the only clock.
REQ-005 SHALL have port rst_n  input  1  synchronous, active-low reset.
REQ-006 SHALL have port start  input  1  one-cycle pulse that begins a fetch run.
REQ-007 SHALL have port busy  output  1  high from the cycle after an accepted start until done.
REQ-008 SHALL have port done  output  1  one-cycle pulse after the last twiddle is accepted downstream.
REQ-009 SHALL have port rom_addr  output  ADDR_W  address driven to the real and imaginary twiddle ROMs.
REQ-010 SHALL have port rom_re  input  DATA_W  real ROM data, valid one cycle after rom_addr.
REQ-011 SHALL have port rom_im  input  DATA_W  imaginary ROM data, valid one cycle after rom_addr.
REQ-012 SHALL have port tw_valid  output  1  twiddle pair available.
REQ-013 SHALL have port tw_ready  input  1  butterfly accepts the pair.
REQ-014 SHALL have port tw_re, tw_im  output  DATA_W each  twiddle pair.
REQ-015 SHALL have port tw_idx  output  ADDR_W  ROM address the current pair came from.

Function
REQ-016 SHALL implement FSM states IDLE, FETCH, DRAIN: IDLE->FETCH on start; FETCH->DRAIN after address NUM_TW-1 is issued; DRAIN->IDLE when the last pair is accepted.
REQ-017 SHALL ignore start while busy is high.
REQ-018 SHALL issue addresses in ascending order 0..NUM_TW-1, at most one per cycle, and never wrap within a run.
REQ-019 SHALL capture ROM data exactly one cycle after the address was issued, tagged with that address.
REQ-020 SHALL buffer captured pairs in a 2-entry FIFO and issue an address only when the in-flight count plus the FIFO occupancy is less than 2, so no pair is ever dropped.
REQ-021 SHALL sustain one pair per cycle with tw_ready held high; first tw_valid is asserted 2 cycles after start.
REQ-022 SHALL transfer a pair only on a cycle with tw_valid and tw_ready both high; tw_re/tw_im/tw_idx SHALL be held stable while tw_valid is high and tw_ready is low.
REQ-023 SHALL pulse done in the cycle after the transfer of tw_idx NUM_TW-1 and drop busy in that same cycle.
REQ-024 SHALL accept a start arriving in the same cycle as done and begin a new run.

Reset
REQ-025 SHALL, when rst_n is low at a clock edge, force state IDLE, rom_addr 0, FIFO empty, in-flight count 0, tw_valid 0, busy 0, done 0, tw_re/tw_im/tw_idx 0.
REQ-026 SHALL abort a run on mid-run reset, discarding in-flight data; no done pulse is emitted.

Configuration
REQ-027 SHALL, with macro TWIDDLE_CONJ_EN defined, output the negation of rom_im on tw_im (conjugate twiddle for inverse FFT), saturating the most negative value to the most positive value; tw_re is unchanged.
REQ-028 SHALL, without TWIDDLE_CONJ_EN, pass rom_im to tw_im unmodified.

Structure
REQ-029 SHALL take the FSM state enum, ADDR_W/DATA_W defaults and NUM_TW from the shared FFT package.
REQ-030 SHALL place the 2-entry buffer in a sub-module named fft_tw_skid_fifo; the ROMs remain external.

Verification
REQ-031 SHALL cover: start with tw_ready=1 and imag ROM returning 16'hFF00 at address 5 -> tw_valid at cycle 2, 28 consecutive transfers, tw_idx 0..27 with tw_im=16'hFF00 at tw_idx 5, done exactly 1 cycle after the last transfer.
REQ-032 SHALL cover: tw_ready toggling 1,0,0,1 repeatedly -> no lost or duplicated tw_idx, outputs stable while stalled, and rom_addr never more than 2 ahead of the last accepted tw_idx.
REQ-033 SHALL cover: rst_n low for one cycle when tw_idx=10 -> all outputs 0 next cycle, no done, and a following start fetches again from address 0.
REQ-034 SHALL cover: start pulsed while busy -> ignored; start in the done cycle -> a new run with rom_addr 0 on the next cycle.
REQ-035 SHALL cover: with TWIDDLE_CONJ_EN, rom_im 16'hFF4A -> tw_im 16'h00B6, and rom_im 16'h8000 -> tw_im 16'h7FFF; without the macro, tw_im equals rom_im.
